// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
//
// One-cycle ops: AND, OR, ADD, SUB, SLT, NOR. An optional unsigned shift-add
// multiplier (MUL) retires one multiplier bit per cycle over WIDTH cycles.
// Each result and its flags are held until the consumer accepts them.
//
// Build option: define SEQ_ALU_MUL_EN to include the multiplier and the BUSY state.
// Without it, alu_op 011 is treated as illegal.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and op presented
//   in_ready   ALU idle and able to accept
//   a, b       operands (WIDTH)
//   alu_op     000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 MUL
//   out_valid  result and flags valid (DONE state)
//   out_ready  consumer accepts the result
//   result     registered result (WIDTH)
//   zero       result == 0
//   carry_out  ADD/SUB carry out of the MSB; MUL: upper product half nonzero
//   overflow   signed overflow, ADD/SUB only
//   illegal    an unsupported alu_op was accepted
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;
  localparam logic [2:0] OpNor = 3'b100;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [2:0]  OpMul   = 3'b011;
  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, res_d;
  logic             zero_q, carry_q, ovf_q, ill_q;
  logic             carry_d, ovf_d, ill_d;
  logic             load;
  logic             accept;

  // Gated by rst_n so nothing is offered while the block is held in reset.
  assign in_ready  = rst_n & (state_q == StIdle);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

  // One-cycle datapath
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ovf, sub_ovf, slt_bit;
  logic [WIDTH-1:0] op_res;
  logic             op_c, op_v, op_ill;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (sub_sum[WIDTH-1] != a[WIDTH-1]);
  // Sign of the difference corrected by overflow gives a true signed compare.
  assign slt_bit = sub_sum[WIDTH-1] ^ sub_ovf;

  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    op_ill = 1'b0;
    case (alu_op)
      OpAnd: op_res = a & b;
      OpOr:  op_res = a | b;
      OpNor: op_res = ~(a | b);
      OpAdd: begin
        op_res = add_sum[WIDTH-1:0];
        op_c   = add_sum[WIDTH];
        op_v   = add_ovf;
      end
      OpSub: begin
        op_res = sub_sum[WIDTH-1:0];
        op_c   = sub_sum[WIDTH];
        op_v   = sub_ovf;
      end
      OpSlt: op_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: op_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  // Shift-add multiplier: prod_q holds {partial sum, unconsumed multiplier bits}.
  logic [2*WIDTH-1:0] prod_q, prod_step;
  logic [WIDTH-1:0]   mcand_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     step_sum;
  logic               mul_last;

  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};
  assign mul_last  = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (accept && (alu_op == OpMul)) begin
      prod_q  <= {{WIDTH{1'b0}}, b};
      mcand_q <= a;
      cnt_q   <= '0;
    end else if (state_q == StBusy) begin
      prod_q  <= prod_step;
      cnt_q   <= cnt_q + 1'b1;
    end
  end
`endif

  // Next state and result load
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_d   = result_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          if (alu_op == OpMul) begin
            state_d = StBusy;
          end else
`endif
          begin
            state_d = StDone;
            load    = 1'b1;
            res_d   = op_res;
            carry_d = op_c;
            ovf_d   = op_v;
            ill_d   = op_ill;
          end
        end
      end
`ifdef SEQ_ALU_MUL_EN
      StBusy: begin
        if (mul_last) begin
          state_d = StDone;
          load    = 1'b1;
          res_d   = prod_step[WIDTH-1:0];
          carry_d = |prod_step[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
        ill_q    <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): table-driven vectors feeding a
// scoreboard queue, plus hand sequences for MUL, backpressure and mid-operation reset.
module tb_seq_alu;

  localparam int unsigned W = 32;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;
  localparam logic [2:0] OpNor = 3'b100;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpBad = 3'b101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [2:0]   alu_op;
  logic         zero, carry_out, overflow, illegal;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] res;
    logic         z, c, v, ill;
    int           lat;  // 0 = latency not checked
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         z, c, v, ill;
    int           lat;
    int           acc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry_out(carry_out),
    .overflow (overflow),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic [W-1:0] res, input logic z,
                              input logic c, input logic v, input logic ill, input int lat);
    vec_t t;
    t.name = name; t.op = op; t.av = av; t.bv = bv; t.res = res;
    t.z = z; t.c = c; t.v = v; t.ill = ill; t.lat = lat;
    return t;
  endfunction

  // Drives one transaction (called at #1 after a posedge); returns #1 after the accept edge.
  task automatic send(input vec_t t);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL %s.accept_timeout: got in_ready 0, expected 1", t.name);
      return;
    end
    in_valid = 1'b1; alu_op = t.op; a = t.av; b = t.bv;
    @(posedge clk); #1;
    e.name = t.name; e.res = t.res; e.z = t.z; e.c = t.c; e.v = t.v; e.ill = t.ill;
    e.lat = t.lat; e.acc = cyc;
    sb.push_back(e);
    // Scramble inputs: they must not matter after accept.
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 3'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL %s.drain_timeout: got %0d pending, expected 0", name, sb.size());
    end
  endtask

  // Output monitor: pops and compares on each completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_output: got result %0h, expected no output", result);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, ".result"},   result,    mon_e.res);
        chk({mon_e.name, ".zero"},     zero,      mon_e.z);
        chk({mon_e.name, ".carry"},    carry_out, mon_e.c);
        chk({mon_e.name, ".overflow"}, overflow,  mon_e.v);
        chk({mon_e.name, ".illegal"},  illegal,   mon_e.ill);
        if (mon_e.lat != 0) chk({mon_e.name, ".latency"}, cyc - mon_e.acc + 1, mon_e.lat);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_op = '0;

    vecs.push_back(mk("and",      OpAnd, 32'ha5a5a5a5, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1));
    vecs.push_back(mk("or",       OpOr,  32'ha5a5a5a5, 32'h00000001, 32'ha5a5a5a5, 0, 0, 0, 0, 1));
    vecs.push_back(mk("add",      OpAdd, 32'ha5a5a5a5, 32'h00000001, 32'ha5a5a5a6, 0, 0, 0, 0, 1));
    vecs.push_back(mk("sub",      OpSub, 32'ha5a5a5a5, 32'h00000001, 32'ha5a5a5a4, 0, 1, 0, 0, 1));
    vecs.push_back(mk("add_ovf",  OpAdd, 32'h7fffffff, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 1));
    vecs.push_back(mk("sub_zero", OpSub, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0, 1));
    vecs.push_back(mk("slt_neg",  OpSlt, 32'hffffffff, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1));
    vecs.push_back(mk("nor",      OpNor, 32'ha5a5a5a5, 32'h00000001, 32'h5a5a5a5a, 0, 0, 0, 0, 1));
    vecs.push_back(mk("add_wrap", OpAdd, 32'hffffffff, 32'h00000001, 32'h00000000, 1, 1, 0, 0, 1));
    vecs.push_back(mk("sub_brw",  OpSub, 32'h00000000, 32'h00000001, 32'hffffffff, 0, 0, 0, 0, 1));
    vecs.push_back(mk("sub_ovf",  OpSub, 32'h80000000, 32'h00000001, 32'h7fffffff, 0, 1, 1, 0, 1));
    vecs.push_back(mk("slt_pos",  OpSlt, 32'h00000001, 32'hffffffff, 32'h00000000, 1, 0, 0, 0, 1));
    vecs.push_back(mk("slt_ov1",  OpSlt, 32'h80000000, 32'h7fffffff, 32'h00000001, 0, 0, 0, 0, 1));
    vecs.push_back(mk("slt_ov0",  OpSlt, 32'h7fffffff, 32'h80000000, 32'h00000000, 1, 0, 0, 0, 1));
    vecs.push_back(mk("and_zero", OpAnd, 32'h0f0f0f0f, 32'hf0f0f0f0, 32'h00000000, 1, 0, 0, 0, 1));
    vecs.push_back(mk("illegal",  OpBad, 32'h00001234, 32'h00005678, 32'h00000000, 1, 0, 0, 1, 1));
`ifdef SEQ_ALU_MUL_EN
    vecs.push_back(mk("mul_7x6",  OpMul, 32'h00000007, 32'h00000006, 32'h0000002a, 0, 0, 0, 0, W+1));
    vecs.push_back(mk("mul_max",  OpMul, 32'hffffffff, 32'hffffffff, 32'h00000001, 0, 1, 0, 0, W+1));
`else
    vecs.push_back(mk("mul_ill",  OpMul, 32'h00000007, 32'h00000006, 32'h00000000, 1, 0, 0, 1, 1));
`endif
    vecs.push_back(mk("add_last", OpAdd, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 0, 1));

    // Reset state
    #3;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result",    result,    0);
    chk("rst.zero",      zero,      0);
    chk("rst.carry",     carry_out, 0);
    chk("rst.overflow",  overflow,  0);
    chk("rst.illegal",   illegal,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst.in_ready", in_ready, 1);

    // Table vectors, back to back
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
    drain("table");

`ifdef SEQ_ALU_MUL_EN
    // MUL whose low half is zero; in_ready must stay low for the whole BUSY phase
    begin
      int busy_ready = 0;
      send(mk("mul_hi", OpMul, 32'h00010000, 32'h00010000, 32'h00000000, 1, 1, 0, 0, W+1));
      for (int i = 0; i < W; i++) begin
        if (in_ready) busy_ready++;
        @(posedge clk); #1;
      end
      chk("mul_hi.busy_in_ready_cycles", busy_ready, 0);
      drain("mul_hi");
    end
`endif

    // Backpressure: result held, no new accept while DONE
    out_ready = 1'b0;
    send(mk("bp_add", OpAdd, 32'h11111111, 32'h22222222, 32'h33333333, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", out_valid, 1);
      chk("bp.result",    result,    32'h33333333);
      chk("bp.in_ready",  in_ready,  0);
      in_valid = 1'b1; alu_op = OpAnd; a = '1; b = '1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.after.out_valid", out_valid, 0);
    chk("bp.after.result",    result,    32'h33333333);
    chk("bp.after.in_ready",  in_ready,  1);
    chk("bp.after.pending",   sb.size(), 0);
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of an operation
`ifdef SEQ_ALU_MUL_EN
    send(mk("rst_mul", OpMul, 32'h00010000, 32'h00000003, 32'h00030000, 0, 0, 0, 0, 0));
    repeat (10) @(posedge clk); #1;
`else
    out_ready = 1'b0;
    send(mk("rst_add", OpAdd, 32'h00000003, 32'h00000004, 32'h00000007, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk); #1;
`endif
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.result",    result,    0);
    chk("midrst.zero",      zero,      0);
    chk("midrst.carry",     carry_out, 0);
    chk("midrst.overflow",  overflow,  0);
    chk("midrst.illegal",   illegal,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("midrst.in_ready", in_ready, 1);
    send(mk("post_rst_add", OpAdd, 32'h7fffffff, 32'h7fffffff, 32'hfffffffe, 0, 0, 1, 0, 1));
    drain("post_rst");
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
